fp_addsub_arbiter: RTL and testbench

//  Shares one fixed-latency FP add/sub datapath (add_sub_main) between NUM_REQ requesters.

---
 rtl/fp_addsub_arbiter_pkg.sv | 6 +
 rtl/fp_addsub_arbiter_if.sv | 14 +
 rtl/fp_addsub_arbiter_rr_arbiter.sv | 21 ++
 rtl/fp_addsub_arbiter.sv | 59 +++++
 tb/tb_fp_addsub_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp_addsub_arbiter_pkg.sv
// fp_addsub_arbiter_pkg: shared types and core latency for the FP add/sub arbiter slice
package fp_addsub_arbiter_pkg;
  typedef logic [31:0] fp_word_t;
  typedef enum logic {FP_ADD = 1'b0, FP_SUB = 1'b1} fp_op_e;
  localparam int FP_CORE_LAT = 3;
endpackage

// File: rtl/fp_addsub_arbiter_if.sv
// fp_addsub_arbiter_if: requester-side request/response bus of the shared FP add/sub arbiter
interface fp_addsub_arbiter_if #(parameter int WIDTH = 32, parameter int NUM_REQ = 4);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] req_op;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic [ID_W-1:0] rsp_id;
  modport master (output req_valid, req_a, req_b, req_op, input req_ready, rsp_valid, rsp_data, rsp_id);
  modport slave (input req_valid, req_a, req_b, req_op, output req_ready, rsp_valid, rsp_data, rsp_id);
endinterface

// File: rtl/fp_addsub_arbiter_rr_arbiter.sv
// fp_addsub_arbiter_rr_arbiter: combinational round-robin pick, search starts at ptr and wraps
module fp_addsub_arbiter_rr_arbiter #(
  parameter int N = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      if (grant == '0 && req[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = ID_W'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: round-robin sharing of one fixed-latency FP add/sub core among NUM_REQ clients,
// with an ID pipe that routes each result back to the requester that issued it.
module fp_addsub_arbiter
  import fp_addsub_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_REQ = 4,
  parameter int CORE_LAT = FP_CORE_LAT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_addsub_arbiter_if.slave   bus,
  output logic [WIDTH-1:0]     core_a,
  output logic [WIDTH-1:0]     core_b,
  output fp_op_e               core_op,
  input  logic [WIDTH-1:0]     core_result,
  output logic                 busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [ID_W-1:0] ptr, win;
  logic [NUM_REQ-1:0] grant;
  logic [CORE_LAT:0] pv;
  logic [ID_W-1:0] pid [CORE_LAT+1];
  logic accept;
  fp_addsub_arbiter_rr_arbiter #(.N(NUM_REQ)) u_rr (.req(bus.req_valid), .ptr(ptr), .grant(grant), .idx(win));
  assign bus.req_ready = grant & {NUM_REQ{rst_n}};
  assign accept = |grant;
  // Stage CORE_LAT lines up with core_result for the op issued CORE_LAT+1 edges earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      core_a <= '0;
      core_b <= '0;
      core_op <= FP_ADD;
      pv <= '0;
      for (int k = 0; k <= CORE_LAT; k++) pid[k] <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data <= '0;
      bus.rsp_id <= '0;
      busy <= 1'b0;
    end else begin
      if (accept) begin
        core_a <= bus.req_a[win*WIDTH +: WIDTH];
        core_b <= bus.req_b[win*WIDTH +: WIDTH];
        core_op <= fp_op_e'(bus.req_op[win]);
        ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
      pv <= {pv[CORE_LAT-1:0], accept};
      pid[0] <= win;
      for (int k = 1; k <= CORE_LAT; k++) pid[k] <= pid[k-1];
      bus.rsp_valid <= pv[CORE_LAT] ? NUM_REQ'(1) << pid[CORE_LAT] : '0;
      if (pv[CORE_LAT]) begin
        bus.rsp_data <= core_result;
        bus.rsp_id <= pid[CORE_LAT];
      end
      busy <= |{pv[CORE_LAT-1:0], accept};
    end
  end
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb_fp_addsub_arbiter: directed steps with a latency-stamped response scoreboard and a behavioural FP core.
module tb_fp_addsub_arbiter;
  import fp_addsub_arbiter_pkg::*;
  localparam int W = 32;
  localparam int N = 4;
  localparam int L = FP_CORE_LAT;

  typedef struct {int id; logic [31:0] data; int due;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] core_a, core_b, core_result;
  fp_op_e core_op;
  logic busy;
  logic [31:0] cp [L];
  exp_t sb [$];
  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  fp_addsub_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  fp_addsub_arbiter #(.WIDTH(W), .NUM_REQ(N), .CORE_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .core_a(core_a), .core_b(core_b),
    .core_op(core_op), .core_result(core_result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real f2r(logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = 11'(x[30:23]) + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpop(logic [31:0] a, logic [31:0] b, logic op);
    return r2f(op ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
  endfunction

  // Behavioural core: result appears L edges after the operands are presented.
  always_ff @(posedge clk) begin
    cp[0] <= fpop(core_a, core_b, core_op);
    for (int k = 1; k < L; k++) cp[k] <= cp[k-1];
  end
  assign core_result = cp[L-1];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(int i, logic [31:0] a, logic [31:0] b, logic op);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_op[i] = op;
  endtask

  task automatic grant_is(logic [N-1:0] exp);
    #1;
    chk("grant", 64'(bus.req_ready), 64'(exp));
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    int w;
    exp_t e;
    #1;
    acc = bus.req_valid & bus.req_ready;
    w = 0;
    for (int i = 0; i < N; i++) if (acc[i]) w = i;
    if (acc != '0)
      sb.push_back('{w, fpop(bus.req_a[w*W +: W], bus.req_b[w*W +: W], bus.req_op[w]), cycle + L + 2});
    @(posedge clk);
    #1;
    cycle++;
    if (sb.size() == 0) begin
      if (bus.rsp_valid != '0) chk("spurious_rsp", 64'(bus.rsp_valid), 64'd0);
    end else if (bus.rsp_valid != '0 || sb[0].due == cycle) begin
      e = sb.pop_front();
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(4'b0001 << e.id));
      chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
      chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
      chk("rsp_cycle", 64'(cycle), 64'(e.due));
    end
    chk("busy", 64'(busy), 64'(sb.size() != 0));
  endtask

  initial begin
    logic [31:0] sa, sbv;
    fp_op_e so;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_core_a", 64'(core_a), 64'd0);
    chk("rst_core_b", 64'(core_b), 64'd0);
    chk("rst_core_op", 64'(core_op), 64'(FP_ADD));
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    bus.req_valid = '0;
    rst_n = 1'b1;

    // Single add on requester 0
    set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
    bus.req_valid = 4'b0001;
    grant_is(4'b0001);
    tick();
    bus.req_valid = '0;
    chk("core_a", 64'(core_a), 64'h3F800000);
    chk("core_b", 64'(core_b), 64'h40000000);
    chk("core_op", 64'(core_op), 64'(FP_ADD));
    repeat (4) tick();
    chk("add_valid", 64'(bus.rsp_valid), 64'b0001);
    chk("add_data", 64'(bus.rsp_data), 64'h40400000);
    chk("add_id", 64'(bus.rsp_id), 64'd0);
    tick();
    chk("add_pulse_end", 64'(bus.rsp_valid), 64'd0);

    // Subtract on requester 2
    set_op(2, 32'h40400000, 32'h3F800000, 1'b1);
    bus.req_valid = 4'b0100;
    grant_is(4'b0100);
    tick();
    bus.req_valid = '0;
    repeat (4) tick();
    chk("sub_valid", 64'(bus.rsp_valid), 64'b0100);
    chk("sub_data", 64'(bus.rsp_data), 64'h40000000);
    chk("sub_id", 64'(bus.rsp_id), 64'd2);
    tick();

    // ptr=3 with 1010: grant 3 then 1, leaving ptr at 2
    set_op(1, r2f(5.0), r2f(1.5), 1'b1);
    set_op(3, r2f(0.75), r2f(2.0), 1'b0);
    bus.req_valid = 4'b1010;
    grant_is(4'b1000);
    tick();
    bus.req_valid = 4'b0010;
    grant_is(4'b0010);
    tick();
    bus.req_valid = 4'b1111;
    grant_is(4'b0100);
    bus.req_valid = '0;
    repeat (6) tick();
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    repeat (5) tick();

    // All four held valid for eight cycles from ptr=0
    for (int i = 0; i < N; i++) set_op(i, r2f(real'(i + 1)), r2f(0.25 * real'(i + 1)), i[0]);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      grant_is(4'b0001 << (k % N));
      tick();
    end
    bus.req_valid = '0;
    repeat (6) tick();

    // Reset one cycle after the third back-to-back accept discards everything in flight
    bus.req_valid = 4'b0111;
    repeat (3) tick();
    bus.req_valid = '0;
    tick();
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    bus.req_valid = 4'b1111;
    #1;
    chk("midrst_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = '0;
    @(posedge clk);
    cycle++;
    #1;
    rst_n = 1'b1;
    repeat (6) tick();
    bus.req_valid = 4'b1111;
    grant_is(4'b0001);
    tick();
    bus.req_valid = '0;
    repeat (5) tick();

    // Idle: nothing granted, core operands hold
    sa = core_a;
    sbv = core_b;
    so = core_op;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_ready", 64'(bus.req_ready), 64'd0);
      chk("idle_core_a", 64'(core_a), 64'(sa));
      chk("idle_core_b", 64'(core_b), 64'(sbv));
      chk("idle_core_op", 64'(core_op), 64'(so));
    end
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
